systolic_tile_sequencer: RTL and testbench
==========================================

// Module: systolic_tile_sequencer
// PURPOSE
//  Feeds and sequences an N x N output-stationary systolic MAC array computing C = A*B for size x size matrices,
//  one N x N C-tile at a time. Accepts one A-column/B-row beat per handshake, applies per-lane input skew,
//  flushes zeros through the array, then pushes accumulators out diagonal by diagonal. Sits between the
//  operand stream and the PE array; the array consumes a_skew/b_skew when pe_en=1 and dumps PEs on push_diag.
// PARAMETERS
//  N   2   array dimension; power of two, >=2
//  DW  8   operand element width (signed)
//  SW  17  width of size input
//  IW  32  width of tile counter; (2^SW/N)^2 must fit
// PORTS
//  clk        in   1      clock; all state changes on posedge
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      begin job; sampled in IDLE only
//  size       in   SW     matrix dimension (unsigned), latched on accepted start
//  in_valid   in   1      a_vec/b_vec beat valid
//  in_ready   out  1      1 in RUN only (combinational from state)
//  a_vec      in   N*DW   A column k; lane i (row i) at [i*DW +: DW]
//  b_vec      in   N*DW   B row k; lane j (column j) at [j*DW +: DW]
//  a_skew     out  N*DW   skewed A lanes to array west edge (registered)
//  b_skew     out  N*DW   skewed B lanes to array north edge (registered)
//  pe_en      out  1      array MAC/shift enable (registered)
//  push_diag  out  2N-1   one-hot; bit d: PEs with i+j==d output and clear accumulators
//  tile_idx   out  IW     index of tile in progress (row-major over C tiles)
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse, whole job complete
//  err_size   out  1      one-cycle pulse, start rejected
// BEHAVIOUR
//  Reset: state IDLE; all outputs, skew regs, counters = 0. Reset wins over every other input.
//  Start: in IDLE with start=1: size==0 or size%N!=0 -> err_size=1 next cycle, stay IDLE; else latch size,
//   total=(size/N)^2, tile_idx=0, -> RUN. start outside IDLE ignored.
//  States: IDLE -> RUN -> FLUSH -> PUSH -> (RUN | DONE) -> IDLE.
//  RUN: beat accepted when in_valid&in_ready (adv=1). step counts 0..size-1; accepting beat size-1 -> FLUSH.
//   in_valid=0: stall, adv=0, skew regs hold, step holds.
//  FLUSH: exactly 2N-2 cycles, adv=1 every cycle, zeros injected into lane inputs.
//  PUSH: exactly 2N-1 cycles, push_diag = 1<<d at PUSH cycle d (d=0..2N-2); adv=0.
//   On last PUSH cycle: tile_idx+1==total -> DONE, else tile_idx++, step=0 -> RUN.
//  DONE: one cycle, done=1; -> IDLE. busy falls the same edge done falls.
//  Skew: lane i is a shift chain of depth i+1 advancing only when adv=1; after the advance accepting
//   beat k, lane i output = beat k-i of current tile, or 0 if k-i<0. Same rule for b_skew lane j.
//   Chains are all-zero at start of each tile (guaranteed by FLUSH).
//  pe_en = adv delayed one cycle (array consumes the value the skew regs just took). PE(i,j) final MAC
//   occurs before PUSH cycle i+j; push_diag never coincides with a live product for that diagonal.
//  Arithmetic: total computed as (size>>log2N)^2 in IW bits, no overflow for legal params; step SW bits.
// TESTING
//  N=2,size=2: start@c0; beats accepted c1,c2; FLUSH c3-c4; push_diag=001,010,100 c5-c7; done=1 c8, busy=0 c9.
//  Skew N=2: beats a_vec={0x22,0x11},{0x44,0x33} -> a_skew(lane1,lane0)= (00,11),(22,33), flush (44,00),(00,00).
//  N=2,size=4, in_valid held 1: tile_idx 0..3, 4 beats each, 4 push triples, single done after 4th tile.
//  Stall: in_valid=0 for 3 cycles mid-tile -> in_ready=1, pe_en=0, a_skew/b_skew/step unchanged; resumes exactly.
//  size=3 (N=2) or size=0 -> err_size pulse 1 cycle, busy stays 0, in_ready 0; start while busy ignored.
//  reset asserted mid-FLUSH (async, no clock edge) -> outputs 0 immediately; after release, new start works.

Source files
------------

// File: rtl/systolic_tile_sequencer.sv
// Operand sequencer for an N x N output-stationary systolic MAC array.
// Skews A/B lanes, flushes the array and pushes accumulators by diagonal.
module systolic_tile_sequencer #(
   parameter int N  = 2,
   parameter int DW = 8,
   parameter int SW = 17,
   parameter int IW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [SW-1:0]   size,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] a_vec,
   input  logic [N*DW-1:0] b_vec,
   output logic [N*DW-1:0] a_skew,
   output logic [N*DW-1:0] b_skew,
   output logic            pe_en,
   output logic [2*N-2:0]  push_diag,
   output logic [IW-1:0]   tile_idx,
   output logic            busy,
   output logic            done,
   output logic            err_size
);

   localparam int LG = $clog2(N);
   localparam int PW = 2*N-1;
   localparam int CW = $clog2(2*N);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_PUSH  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state;
   logic [SW-1:0] size_q;
   logic [SW-1:0] step;
   logic [IW-1:0] total;
   logic [IW-1:0] side;
   logic [CW-1:0] cnt;
   logic          adv;
   logic          last_beat;
   logic          bad_size;

   assign in_ready  = (state == S_RUN);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign adv       = (in_ready && in_valid) || (state == S_FLUSH);
   assign last_beat = (step == size_q - SW'(1));
   assign side      = IW'(size >> LG);
   assign bad_size  = (size == '0) || (size[LG-1:0] != '0);

   always_comb begin
      push_diag = '0;
      if (state == S_PUSH)
         push_diag = PW'(1) << cnt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         size_q   <= '0;
         step     <= '0;
         total    <= '0;
         cnt      <= '0;
         tile_idx <= '0;
         pe_en    <= 1'b0;
         err_size <= 1'b0;
      end else begin
         err_size <= 1'b0;
         pe_en    <= adv;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  if (bad_size) begin
                     err_size <= 1'b1;
                  end else begin
                     size_q   <= size;
                     total    <= side * side;
                     tile_idx <= '0;
                     step     <= '0;
                     state    <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (adv) begin
                  if (last_beat) begin
                     cnt   <= '0;
                     state <= S_FLUSH;
                  end else begin
                     step <= step + SW'(1);
                  end
               end
            end
            S_FLUSH: begin
               if (cnt == CW'(2*N-3)) begin
                  cnt   <= '0;
                  state <= S_PUSH;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_PUSH: begin
               if (cnt == CW'(2*N-2)) begin
                  cnt <= '0;
                  if (tile_idx + IW'(1) == total) begin
                     state <= S_DONE;
                  end else begin
                     tile_idx <= tile_idx + IW'(1);
                     step     <= '0;
                     state    <= S_RUN;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // lane i delays its operand by i advances; flush cycles shift in zeros
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] ca [i+1];
      logic [DW-1:0] cb [i+1];
      logic [DW-1:0] a_in;
      logic [DW-1:0] b_in;

      assign a_in = in_ready ? a_vec[i*DW +: DW] : '0;
      assign b_in = in_ready ? b_vec[i*DW +: DW] : '0;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k <= i; k++) begin
               ca[k] <= '0;
               cb[k] <= '0;
            end
         end else if (adv) begin
            ca[0] <= a_in;
            cb[0] <= b_in;
            for (int k = 1; k <= i; k++) begin
               ca[k] <= ca[k-1];
               cb[k] <= cb[k-1];
            end
         end
      end

      assign a_skew[i*DW +: DW] = ca[i];
      assign b_skew[i*DW +: DW] = cb[i];
   end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed bench for systolic_tile_sequencer at N=2, DW=8.
// Cycle table for one 2x2 job plus stall, reset and multi-tile runs.
module tb_systolic_tile_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [16:0] size;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_vec;
   logic [15:0] b_vec;
   logic [15:0] a_skew;
   logic [15:0] b_skew;
   logic        pe_en;
   logic [2:0]  push_diag;
   logic [31:0] tile_idx;
   logic        busy;
   logic        done;
   logic        err_size;

   int total;
   int bad;

   systolic_tile_sequencer #(
      .N(2), .DW(8), .SW(17), .IW(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .size(size),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a_vec(a_vec),
      .b_vec(b_vec),
      .a_skew(a_skew),
      .b_skew(b_skew),
      .pe_en(pe_en),
      .push_diag(push_diag),
      .tile_idx(tile_idx),
      .busy(busy),
      .done(done),
      .err_size(err_size)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [16:0] sz;
      logic        v;
      logic [15:0] a;
      logic [15:0] b;
      logic        rdy;
      logic        bsy;
      logic        pe;
      logic [15:0] as;
      logic [15:0] bs;
      logic [2:0]  pd;
      logic        dn;
      logic        er;
      logic [31:0] ti;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic [16:0] sz,
                        input logic v, input logic [15:0] a,
                        input logic [15:0] b);
      start    = st;
      size     = sz;
      in_valid = v;
      a_vec    = a;
      b_vec    = b;
   endtask

   int beats;
   int pushes;
   int dones;
   int c;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);

      tbl[0]  = '{1,2,0,16'h0,16'h0,    1,1,0,16'h0,16'h0,0,0,0,0};
      tbl[1]  = '{0,0,1,16'h2211,16'h6655,
                  1,1,1,16'h0011,16'h0055,0,0,0,0};
      tbl[2]  = '{0,0,1,16'h4433,16'h8877,
                  0,1,1,16'h2233,16'h6677,0,0,0,0};
      tbl[3]  = '{0,0,1,16'hffff,16'hffff,
                  0,1,1,16'h4400,16'h8800,0,0,0,0};
      tbl[4]  = '{0,0,1,16'hffff,16'hffff,
                  0,1,1,16'h0,16'h0,3'b001,0,0,0};
      tbl[5]  = '{0,0,1,16'hffff,16'hffff,
                  0,1,0,16'h0,16'h0,3'b010,0,0,0};
      tbl[6]  = '{0,0,0,16'h0,16'h0,    0,1,0,16'h0,16'h0,3'b100,0,0,0};
      tbl[7]  = '{0,0,0,16'h0,16'h0,    0,1,0,16'h0,16'h0,0,1,0,0};
      tbl[8]  = '{1,2,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,0,0,0,0};
      tbl[9]  = '{1,3,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,0,0,1,0};
      tbl[10] = '{0,0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,0,0,0,0};
      tbl[11] = '{1,0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,0,0,1,0};
      tbl[12] = '{0,0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,0,0,0,0};

      tick();
      tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdy", 32'(in_ready), 0);
      chk("rst_pe", 32'(pe_en), 0);
      chk("rst_as", 32'(a_skew), 0);
      chk("rst_bs", 32'(b_skew), 0);
      chk("rst_pd", 32'(push_diag), 0);
      chk("rst_ti", tile_idx, 0);
      chk("rst_dn", 32'(done), 0);
      chk("rst_er", 32'(err_size), 0);
      reset = 1'b0;
      tick();

      for (int r = 0; r < 13; r++) begin
         drive(tbl[r].st, tbl[r].sz, tbl[r].v, tbl[r].a, tbl[r].b);
         tick();
         chk($sformatf("r%0d_rdy", r), 32'(in_ready), 32'(tbl[r].rdy));
         chk($sformatf("r%0d_bsy", r), 32'(busy), 32'(tbl[r].bsy));
         chk($sformatf("r%0d_pe", r), 32'(pe_en), 32'(tbl[r].pe));
         chk($sformatf("r%0d_as", r), 32'(a_skew), 32'(tbl[r].as));
         chk($sformatf("r%0d_bs", r), 32'(b_skew), 32'(tbl[r].bs));
         chk($sformatf("r%0d_pd", r), 32'(push_diag), 32'(tbl[r].pd));
         chk($sformatf("r%0d_dn", r), 32'(done), 32'(tbl[r].dn));
         chk($sformatf("r%0d_er", r), 32'(err_size), 32'(tbl[r].er));
         chk($sformatf("r%0d_ti", r), tile_idx, tbl[r].ti);
      end

      // stall mid-tile, with start pulses that must be ignored
      drive(1, 4, 0, 0, 0);
      tick();
      chk("st_rdy0", 32'(in_ready), 1);
      drive(0, 0, 1, 16'h0201, 16'h1211);
      tick();
      chk("st_as0", 32'(a_skew), 32'h0001);
      chk("st_bs0", 32'(b_skew), 32'h0011);
      drive(0, 0, 1, 16'h0403, 16'h1413);
      tick();
      chk("st_as1", 32'(a_skew), 32'h0203);
      chk("st_pe1", 32'(pe_en), 1);
      for (int s = 0; s < 3; s++) begin
         drive(1, 3, 0, 16'hdead, 16'hbeef);
         tick();
         chk($sformatf("stall%0d_rdy", s), 32'(in_ready), 1);
         chk($sformatf("stall%0d_pe", s), 32'(pe_en), 0);
         chk($sformatf("stall%0d_as", s), 32'(a_skew), 32'h0203);
         chk($sformatf("stall%0d_bs", s), 32'(b_skew), 32'h1213);
         chk($sformatf("stall%0d_er", s), 32'(err_size), 0);
      end
      drive(0, 0, 1, 16'h0605, 16'h1615);
      tick();
      chk("res_as2", 32'(a_skew), 32'h0405);
      chk("res_bs2", 32'(b_skew), 32'h1415);
      chk("res_pe2", 32'(pe_en), 1);
      chk("res_rdy2", 32'(in_ready), 1);
      drive(0, 0, 1, 16'h0807, 16'h1817);
      tick();
      chk("res_as3", 32'(a_skew), 32'h0607);
      chk("res_rdy3", 32'(in_ready), 0);
      drive(0, 0, 0, 0, 0);
      tick();
      chk("fl_as", 32'(a_skew), 32'h0800);
      chk("fl_bs", 32'(b_skew), 32'h1800);

      // asynchronous reset in the middle of FLUSH
      #2;
      reset = 1'b1;
      #1;
      chk("ar_busy", 32'(busy), 0);
      chk("ar_pe", 32'(pe_en), 0);
      chk("ar_as", 32'(a_skew), 0);
      chk("ar_bs", 32'(b_skew), 0);
      chk("ar_rdy", 32'(in_ready), 0);
      @(negedge clk);
      reset = 1'b0;

      // size=4 with in_valid held: four tiles, one done
      beats  = 0;
      pushes = 0;
      dones  = 0;
      drive(1, 4, 1, 16'h0101, 16'h0202);
      tick();
      start = 1'b0;
      for (c = 0; c < 200; c++) begin
         if (in_ready) beats++;
         if (push_diag == 3'b001) begin
            pushes++;
            chk($sformatf("h_ti%0d", pushes), tile_idx, 32'(pushes - 1));
         end
         if (done) begin
            dones++;
            chk("h_ti_done", tile_idx, 3);
         end
         if (dones > 0 && !busy) break;
         tick();
      end
      chk("h_timeout", 32'(c < 200), 1);
      chk("h_beats", 32'(beats), 16);
      chk("h_pushes", 32'(pushes), 4);
      chk("h_dones", 32'(dones), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
